// File: rtl/uart_tx_streamer.sv
// UART 8N1 transmitter fed by a byte FIFO; frames leave LSB-first on io_tx and
// a level interrupt flags that every queued byte has fully left the wire.
module uart_tx_streamer #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          io_enq_valid,
    output logic                          io_enq_ready,
    input  logic [7:0]                    io_enq_bits,
    input  logic                          io_enable,
    input  logic                          io_irq_en,
    output logic                          io_tx,
    output logic                          io_busy,
    output logic [$clog2(FIFO_DEPTH):0]   io_count,
    output logic                          io_tx_irq
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t              state_r, state_s;
    logic [BAUD_W-1:0]   baud_r, baud_s;
    logic [2:0]          bit_idx_r, bit_idx_s;
    logic [7:0]          shift_r, shift_s;
    logic                tx_r, tx_s;
    logic [PTR_W-1:0]    head_r, tail_r;
    logic [CNT_W-1:0]    count_r, count_s;
    logic [7:0]          mem_r [FIFO_DEPTH];
    logic                push_s, pop_s, has_data_s, baud_last_s, start_ok_s;

    assign io_enq_ready = (count_r < CNT_FULL);
    assign push_s       = io_enq_valid && io_enq_ready;
    assign has_data_s   = (count_r != {CNT_W{1'b0}});
    assign baud_last_s  = (baud_r == BAUD_LAST);
    // A new frame may only begin when permitted and a byte is actually queued.
    assign start_ok_s   = io_enable && has_data_s;

    assign io_tx     = tx_r;
    assign io_busy   = (state_r != ST_IDLE);
    assign io_count  = count_r;
    assign io_tx_irq = io_irq_en && !has_data_s && (state_r == ST_IDLE);

    // Frame sequencer: next state, baud/bit counters, shift register and line level.
    always_comb begin
        state_s   = state_r;
        baud_s    = baud_r;
        bit_idx_s = bit_idx_r;
        shift_s   = shift_r;
        tx_s      = tx_r;
        pop_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                baud_s = {BAUD_W{1'b0}};
                if (start_ok_s) begin
                    state_s   = ST_START;
                    pop_s     = 1'b1;
                    shift_s   = mem_r[head_r];
                    bit_idx_s = 3'd0;
                    tx_s      = 1'b0;
                end else begin
                    tx_s = 1'b1;
                end
            end
            ST_START: begin
                if (baud_last_s) begin
                    state_s   = ST_DATA;
                    baud_s    = {BAUD_W{1'b0}};
                    bit_idx_s = 3'd0;
                    tx_s      = shift_r[0];
                end else begin
                    baud_s = baud_r + BAUD_W'(1);
                end
            end
            ST_DATA: begin
                if (baud_last_s) begin
                    baud_s = {BAUD_W{1'b0}};
                    if (bit_idx_r == 3'd7) begin
                        state_s = ST_STOP;
                        tx_s    = 1'b1;
                    end else begin
                        shift_s   = {1'b0, shift_r[7:1]};
                        bit_idx_s = bit_idx_r + 3'd1;
                        tx_s      = shift_r[1];
                    end
                end else begin
                    baud_s = baud_r + BAUD_W'(1);
                end
            end
            ST_STOP: begin
                if (baud_last_s) begin
                    baud_s = {BAUD_W{1'b0}};
                    if (start_ok_s) begin
                        // Chain straight into the next start bit: no idle gap.
                        state_s   = ST_START;
                        pop_s     = 1'b1;
                        shift_s   = mem_r[head_r];
                        bit_idx_s = 3'd0;
                        tx_s      = 1'b0;
                    end else begin
                        state_s = ST_IDLE;
                        tx_s    = 1'b1;
                    end
                end else begin
                    baud_s = baud_r + BAUD_W'(1);
                end
            end
            default: begin
                state_s   = ST_IDLE;
                baud_s    = {BAUD_W{1'b0}};
                bit_idx_s = 3'd0;
                tx_s      = 1'b1;
            end
        endcase
    end

    // FIFO occupancy after the edge; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_s = count_r + CNT_W'(1);
            2'b01:   count_s = count_r - CNT_W'(1);
            default: count_s = count_r;
        endcase
    end

    // State, counters, pointers and line register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            baud_r    <= {BAUD_W{1'b0}};
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
            tx_r      <= 1'b1;
            head_r    <= {PTR_W{1'b0}};
            tail_r    <= {PTR_W{1'b0}};
            count_r   <= {CNT_W{1'b0}};
        end else begin
            state_r   <= state_s;
            baud_r    <= baud_s;
            bit_idx_r <= bit_idx_s;
            shift_r   <= shift_s;
            tx_r      <= tx_s;
            count_r   <= count_s;
            if (push_s) begin
                tail_r <= tail_r + PTR_W'(1);
            end
            if (pop_s) begin
                head_r <= head_r + PTR_W'(1);
            end
        end
    end

    // Byte storage; only written on an accepted enqueue, so later bus changes are ignored.
    always_ff @(posedge clock) begin
        if (push_s) begin
            mem_r[tail_r] <= io_enq_bits;
        end
    end

endmodule

// File: doc/uart_tx_streamer.md
Name: uart_tx_streamer

Overview:
- UART 8N1 transmitter with an input byte FIFO; the outbound counterpart of the SoC UART receive path that the bootloader polls.
- Producers (CPU store path, DMA, or bench) push bytes over a valid/ready handshake.
- The block serializes each byte LSB-first on io_tx at a fixed bit period.
- It raises a level interrupt when all queued data has left the wire.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per bit (115200 baud at 100 MHz); legal minimum 2.
- FIFO_DEPTH, 8, byte entries; power of two, minimum 2.

Ports:
- clock  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high; flushes FIFO and FSM.
- io_enq_valid  input  1  producer presents byte.
- io_enq_ready  output  1  FIFO can accept; equals (count < FIFO_DEPTH).
- io_enq_bits  input  8  byte to transmit.
- io_enable  input  1  permits starting new frames.
- io_irq_en  input  1  interrupt mask.
- io_tx  output  1  serial line, idle high.
- io_busy  output  1  FSM not IDLE.
- io_count  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- io_tx_irq  output  1  io_irq_en && FIFO empty && FSM IDLE.

Behaviour:
- Clock and reset: one clock domain; reset is synchronous and active-high.
- Reset values: io_tx=1, io_busy=0, io_count=0, io_enq_ready=1, FSM=IDLE, baud counter=0, bit index=0. io_tx_irq then equals io_irq_en (combinational from registered state).
- Enqueue: a byte is accepted on a rising edge with io_enq_valid && io_enq_ready. When full, ready is low and bits are ignored.
- Enqueue and dequeue on the same edge: io_count is unchanged. The byte is written at tail and head is popped; pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP.
- IDLE -> START at an edge where io_enable && count>0.
  - The head byte is popped into the shift register.
  - The baud counter clears and io_tx is driven 0 from that edge.
- Latency: a byte accepted at edge N into an empty idle block with io_enable=1 makes io_tx fall after edge N+1.
- Baud counter: counts 0..CLKS_PER_BIT-1. Each bit is held exactly CLKS_PER_BIT cycles.
- START -> DATA at the terminal count. Bit index goes to 0 and io_tx = shift[0].
- DATA: at each terminal count, shift right and advance the bit index. After bit 7's period completes, go to STOP with io_tx=1.
- STOP: held CLKS_PER_BIT cycles. At its terminal count:
  - if io_enable && count>0, go directly to START (pop, io_tx=0, no idle cycle between frames);
  - otherwise go to IDLE.
- Frame length: exactly 10*CLKS_PER_BIT cycles. Back-to-back frames are gapless.
- io_enable deasserted mid-frame: the current frame completes unchanged. No new frame starts until it is reasserted. Queued bytes are retained.
- Reset mid-frame: at the reset edge io_tx returns to 1 and the FIFO is emptied. No partial-frame completion.
- io_enq_bits is sampled only on the accept edge. Later changes do not affect queued data.
- io_count reflects occupancy after the edge. A pop at START decrements it in the same edge as the FSM transition.

Test Plan:
- Single byte (CLKS_PER_BIT=16): push 0x03 with enable=1 → io_tx low for 16 cycles, then bits 1,1,0,0,0,0,0,0 at 16 cycles each, then high 16 cycles. io_busy high for 160 cycles. io_tx_irq (irq_en=1) low from accept through the end of stop, then high.
- Burst: push 0x01,0x02,0x03,0x04 on consecutive cycles → four contiguous frames totalling 640 cycles with no idle-high gap beyond stop bits. A bench UART receiver decodes 1,2,3,4 in order.
- Full FIFO: enable=0, push 0x10..0x17 → io_count=8 and io_enq_ready=0 after the 8th. A 9th push of 0x18 is not accepted. Then enable=1 → exactly eight frames, 0x10..0x17, then io_count=0 and irq high.
- Enable drop: start frame 0xA5 with 0x5A queued, deassert enable at cycle 40 → 0xA5 completes fully and io_tx stays high. io_count=1 persists. Reassert → 0x5A transmitted.
- Simultaneous: count=3, push on the same edge a STOP→START pop occurs → io_count stays 3 and byte order is preserved.
- Reset mid-frame: assert reset at cycle 70 of a 0xFF frame with 2 queued → the next cycle shows io_tx=1, io_busy=0, io_count=0. No further frames after reset release.
